// File: rtl/roll_capture.sv
`timescale 1ns/1ps
// roll_capture: turns raw pinsetter sensor data into a per-ball pin count for
// the score board. It debounces pin settling after each ball, tracks the ball
// index within a frame (including the tenth-frame bonus balls), and asks the
// pinsetter for a full rack whenever the frame rules call for one.
//
// Handshake: the score board has no back-pressure. `update` is a one-cycle
// valid strobe and `N` is held from that cycle until the next update.
// `rerack` is a one-cycle request. `rack_ready` is a level that, together
// with all ten pins standing, completes that request.
//
// dbg_state_o exposes the FSM state. Encoding: 0 WAIT_RACK, 1 ARMED,
// 2 SETTLE, 3 SAMPLE, 4 EMIT, 5 RERACK, 6 HALT.
module roll_capture #(
  parameter int SETTLE_CYC  = 16,
  parameter int TIMEOUT_CYC = 1024,
  parameter int CNT_W       = 11
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] pins,
  input  logic       ball_det,
  input  logic       rack_ready,
  input  logic [3:0] frame,
  input  logic       game_done,
  output logic       update,
  output logic [3:0] N,
  output logic       rerack,
  output logic [1:0] ball,
  output logic       err,
  output logic [2:0] dbg_state_o
);

  typedef enum logic [2:0] {
    S_WAIT_RACK = 3'd0,
    S_ARMED     = 3'd1,
    S_SETTLE    = 3'd2,
    S_SAMPLE    = 3'd3,
    S_EMIT      = 3'd4,
    S_RERACK    = 3'd5,
    S_HALT      = 3'd6
  } state_e;

  state_e           state_q, state_d;
  logic [9:0]       mask_q, mask_d;
  logic [9:0]       prev_q, prev_d;
  logic [CNT_W-1:0] stable_q, stable_d;
  logic [CNT_W-1:0] tmo_q, tmo_d;
  logic [3:0]       f_lat_q, f_lat_d;
  logic             fs_q, fs_d;
  logic             all_down_q, all_down_d;
  logic [1:0]       ball_q, ball_d;
  logic [3:0]       n_q, n_d;
  logic             err_q, err_d;

  logic [9:0]       knocked;
  logic [3:0]       pop_cnt;

  // Pins that were standing at the start of the ball and are down now;
  // ghost pins (standing now but not in the mask) are excluded.
  always_comb begin
    knocked = mask_q & ~pins;
    pop_cnt = '0;
    for (int i = 0; i < 10; i++) begin
      pop_cnt = pop_cnt + {3'b000, knocked[i]};
    end
  end

  // Next-state logic: settling, sampling and the frame/ball sequencing rules.
  always_comb begin
    state_d    = state_q;
    mask_d     = mask_q;
    prev_d     = prev_q;
    stable_d   = stable_q;
    tmo_d      = tmo_q;
    f_lat_d    = f_lat_q;
    fs_d       = fs_q;
    all_down_d = all_down_q;
    ball_d     = ball_q;
    n_d        = n_q;
    err_d      = err_q;
    case (state_q)
      S_WAIT_RACK: begin
        if (rack_ready && (pins == 10'h3FF)) begin
          mask_d  = 10'h3FF;
          state_d = S_ARMED;
        end
      end
      S_ARMED: begin
        // A finished game wins over a ball arriving in the same cycle.
        if (game_done) begin
          state_d = S_HALT;
        end else if (ball_det) begin
          state_d  = S_SETTLE;
          f_lat_d  = frame;
          stable_d = '0;
          tmo_d    = '0;
          prev_d   = pins;
        end
      end
      S_SETTLE: begin
        tmo_d    = tmo_q + 1'b1;
        stable_d = (pins == prev_q) ? stable_q + 1'b1 : '0;
        prev_d   = pins;
        if (stable_d == CNT_W'(SETTLE_CYC - 1)) begin
          state_d = S_SAMPLE;
        end else if (tmo_d == CNT_W'(TIMEOUT_CYC - 1)) begin
          // Pins never settled: take what is there and flag it.
          state_d = S_SAMPLE;
          err_d   = 1'b1;
        end
      end
      S_SAMPLE: begin
        n_d        = pop_cnt;
        if ((pins & ~mask_q) != 10'h000) err_d = 1'b1;
        mask_d     = mask_q & pins;
        all_down_d = ((mask_q & pins) == 10'h000);
        state_d    = S_EMIT;
      end
      S_EMIT: begin
        if (f_lat_q != 4'd10) begin
          if (ball_q == 2'd0 && !all_down_q) begin
            state_d = S_ARMED;
            ball_d  = 2'd1;
          end else begin
            state_d = S_RERACK;
            ball_d  = 2'd0;
          end
        end else begin
          case (ball_q)
            2'd0: begin
              fs_d    = all_down_q;
              state_d = all_down_q ? S_RERACK : S_ARMED;
              ball_d  = 2'd1;
            end
            2'd1: begin
              if (fs_q) begin
                state_d = all_down_q ? S_RERACK : S_ARMED;
                ball_d  = 2'd2;
              end else if (all_down_q) begin
                state_d = S_RERACK;
                ball_d  = 2'd2;
              end else begin
                state_d = S_HALT;
              end
            end
            default: state_d = S_HALT;
          endcase
        end
      end
      S_RERACK: state_d = S_WAIT_RACK;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_WAIT_RACK;
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_WAIT_RACK;
      mask_q     <= 10'h3FF;
      prev_q     <= 10'h000;
      stable_q   <= '0;
      tmo_q      <= '0;
      f_lat_q    <= 4'd0;
      fs_q       <= 1'b0;
      all_down_q <= 1'b0;
      ball_q     <= 2'd0;
      n_q        <= 4'd0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      mask_q     <= mask_d;
      prev_q     <= prev_d;
      stable_q   <= stable_d;
      tmo_q      <= tmo_d;
      f_lat_q    <= f_lat_d;
      fs_q       <= fs_d;
      all_down_q <= all_down_d;
      ball_q     <= ball_d;
      n_q        <= n_d;
      err_q      <= err_d;
    end
  end

  // Strobes decode directly from the registered state, so they can never overlap.
  assign update      = (state_q == S_EMIT);
  assign rerack      = (state_q == S_RERACK);
  assign N           = n_q;
  assign ball        = ball_q;
  assign err         = err_q;
  assign dbg_state_o = state_q;

endmodule
